// File: rtl/ttl_pkg.sv
// Shared definitions for the clocked TTL library models.
package ttl_pkg;

    // Typical and worst-case 74LS propagation delays, ns.
    localparam int TTL_LS_DELAY_TYP = 10;
    localparam int TTL_LS_DELAY_MAX = 15;

    // Per-cycle operating mode of a shift-register model, in priority order.
    typedef enum logic [1:0] {
        MODE_RESET = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_HOLD  = 2'd3
    } shift_mode_e;

endpackage : ttl_pkg

// File: rtl/ttl_bit_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle wrap pulse.
// clr has priority over inc; wrap is low on every cycle that does not
// complete a full count.
module ttl_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q, count_d;
    logic          wrap_q, wrap_d;

    // Next count: clear, wrap at WIDTH-1, increment, or hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule : ttl_bit_counter

// File: rtl/ttl_74165.sv
// Clocked 74LS165 parallel-in/serial-out shift register with shift counter
// and word-complete pulse. Load is synchronous. D[WIDTH-1] (pin H) leaves
// first; SER enters at bit 0 so parts cascade QH -> SER.
// DELAY_RISE/DELAY_FALL describe the output timing of the library model;
// the synthesized outputs are plain registered signals.
module ttl_74165
    import ttl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = TTL_LS_DELAY_MAX,
    parameter int DELAY_FALL = TTL_LS_DELAY_MAX,
    parameter int CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SH_LD_n,
    input  logic             CLK_INH,
    input  logic             SER,
    input  logic [WIDTH-1:0] D,
    output logic             QH,
    output logic             QH_n,
    output logic [CW-1:0]    BIT_CNT,
    output logic             DONE
);

    // Reject unusable parameterisations at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("ttl_74165: WIDTH must be at least 2");
    end
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
        $error("ttl_74165: propagation delays must be non-negative");
    end

    shift_mode_e      mode;
    logic [WIDTH-1:0] sr_q, sr_d;

    // Mode decode: RST > load > shift > hold; CLK_INH is ignored while loading.
    always_comb begin
        mode = MODE_HOLD;
        if (RST)
            mode = MODE_RESET;
        else if (!SH_LD_n)
            mode = MODE_LOAD;
        else if (!CLK_INH)
            mode = MODE_SHIFT;
    end

    // Shift register next state for the decoded mode.
    always_comb begin
        sr_d = sr_q;
        case (mode)
            MODE_RESET: sr_d = '0;
            MODE_LOAD:  sr_d = D;
            MODE_SHIFT: sr_d = {sr_q[WIDTH-2:0], SER};
            default:    sr_d = sr_q;
        endcase
    end

    // Shift register state.
    always_ff @(posedge CLK) begin
        if (RST)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

    // A load clears the count, so a load on the would-be wrap cycle gives no DONE.
    ttl_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk   (CLK),
        .rst   (RST),
        .clr   (mode == MODE_LOAD),
        .inc   (mode == MODE_SHIFT),
        .count (BIT_CNT),
        .wrap  (DONE)
    );

    assign QH   = sr_q[WIDTH-1];
    assign QH_n = ~sr_q[WIDTH-1];

endmodule : ttl_74165

// File: tb/tb_ttl_74165.sv
// Directed bench for ttl_74165 (WIDTH=8). Inputs change on the falling
// edge; outputs are sampled on the next falling edge, 20 ns after the
// rising edge with the 40 ns clock.
module tb_ttl_74165;

    logic       clk = 1'b0;
    logic       rst;
    logic       sh_ld_n;
    logic       clk_inh;
    logic       ser;
    logic [7:0] d;
    logic       qh;
    logic       qh_n;
    logic [2:0] bit_cnt;
    logic       done;

    int errors = 0;
    int checks = 0;

    // 40 ns clock.
    always #20 clk = ~clk;

    ttl_74165 #(
        .WIDTH      (8),
        .DELAY_RISE (15),
        .DELAY_FALL (15)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .SH_LD_n (sh_ld_n),
        .CLK_INH (clk_inh),
        .SER     (ser),
        .D       (d),
        .QH      (qh),
        .QH_n    (qh_n),
        .BIT_CNT (bit_cnt),
        .DONE    (done)
    );

    // Apply one cycle of inputs, then wait to the next falling edge.
    task automatic step(input logic r, input logic ld_n, input logic inh,
                        input logic s, input logic [7:0] dv);
        rst     = r;
        sh_ld_n = ld_n;
        clk_inh = inh;
        ser     = s;
        d       = dv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] dv);
        step(1'b0, 1'b0, 1'b0, 1'b0, dv);
    endtask

    task automatic shift(input logic s);
        step(1'b0, 1'b1, 1'b0, s, 8'h00);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all four outputs against expected QH, BIT_CNT and DONE.
    task automatic check_out(input string tag, input logic e_qh,
                             input logic [2:0] e_cnt, input logic e_done);
        check({tag, ".qh"},   {31'd0, qh},      {31'd0, e_qh});
        check({tag, ".qh_n"}, {31'd0, qh_n},    {31'd0, ~e_qh});
        check({tag, ".cnt"},  {29'd0, bit_cnt}, {29'd0, e_cnt});
        check({tag, ".done"}, {31'd0, done},    {31'd0, e_done});
    endtask

    logic [8:0] a5_qh;

    initial begin
        rst = 1'b1; sh_ld_n = 1'b0; clk_inh = 1'b0; ser = 1'b0; d = 8'hFF;
        @(negedge clk);

        // Reset for two cycles, overriding a load of 8'hFF.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        check_out("reset", 1'b0, 3'd0, 1'b0);

        // Load 8'hA5 then 8 shifts of 0: QH = 1,0,1,0,0,1,0,1 then SER (0).
        a5_qh = 9'b0_1010_0101;
        load(8'hA5);
        check_out("a5_load", a5_qh[7], 3'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            shift(1'b0);
            check_out($sformatf("a5_shift%0d", k), (k == 8) ? 1'b0 : a5_qh[7-k],
                      3'(k % 8), (k == 8));
        end

        // Inhibit: 8'hC3, 3 shifts -> QH=D[4]=0, count 3; hold 4 cycles.
        load(8'hC3);
        check_out("c3_load", 1'b1, 3'd0, 1'b0);
        for (int k = 1; k <= 3; k++) shift(1'b0);
        check_out("c3_shift3", 1'b0, 3'd3, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
            check_out($sformatf("c3_hold%0d", k), 1'b0, 3'd3, 1'b0);
        end
        // C3 = 1100_0011: after shifts 4..7 QH = D[3..0] = 0,0,1,1.
        for (int k = 4; k <= 7; k++) begin
            shift(1'b0);
            check_out($sformatf("c3_shift%0d", k), (k >= 6), 3'(k), 1'b0);
        end
        shift(1'b0);
        check_out("c3_shift8", 1'b0, 3'd0, 1'b1);
        shift(1'b0);
        check_out("c3_after", 1'b0, 3'd1, 1'b0);

        // Streaming: load 0, 16 shifts of SER=1.
        load(8'h00);
        check_out("stream_load", 1'b0, 3'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            shift(1'b1);
            check_out($sformatf("stream%0d", k), (k >= 8), 3'(k % 8),
                      (k == 8 || k == 16));
        end

        // Load collision on the would-be wrap cycle.
        load(8'h81);
        for (int k = 1; k <= 7; k++) shift(1'b0);
        check_out("coll_shift7", 1'b1, 3'd7, 1'b0);
        load(8'h7E);
        check_out("coll_load", 1'b0, 3'd0, 1'b0);
        shift(1'b0);
        check_out("coll_next", 1'b1, 3'd1, 1'b0);

        // Reset mid-word discards the word.
        load(8'hFF);
        for (int k = 1; k <= 4; k++) shift(1'b0);
        check_out("rmw_shift4", 1'b1, 3'd4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        check_out("rmw_reset", 1'b0, 3'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            shift(1'b0);
            check_out($sformatf("rmw_post%0d", k), 1'b0, 3'(k), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ttl_74165
